// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and run control for the 8-bit single-cycle core.
// Owns the IDLE/RUN/DONE run state, the start/done handshake, BNE relative
// branching on the ALU result, and a saturating retired-instruction counter.
module pc_sequencer #(
   parameter int PC_W       = 10,
   parameter int START_ADDR = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             halt,
   input  logic             is_bne,
   input  logic [7:0]       alu_rslt,
   output logic [PC_W-1:0]  pc,
   output logic             run,
   output logic             done,
   output logic [CNT_W-1:0] retired
);

   localparam logic [PC_W-1:0]  START_PC = START_ADDR[PC_W-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [PC_W-1:0]  pc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [PC_W-1:0]  br_off;

   // ALU result is a signed 8-bit offset; widen to the address width
   assign br_off = {{(PC_W-8){alu_rslt[7]}}, alu_rslt};

   // Next state, next pc and next retired count
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cnt_nxt   = retired;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = START_PC;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            // A stalled instruction does not retire; flags are ignored
            if (!stall) begin
               if (retired != CNT_MAX)
                  cnt_nxt = retired + 1'b1;
               if (halt)
                  state_nxt = DONE;          // pc keeps pointing at the HALT
               else if (is_bne && (alu_rslt != 8'd0))
                  pc_nxt = pc + br_off;      // truncates mod 2^PC_W
               else
                  pc_nxt = pc + 1'b1;        // zero offset means not taken
            end
         end
         default: begin
            state_nxt = IDLE;
            pc_nxt    = START_PC;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and output registers; run/done decoded from the next state so
   // they are plain flops with no input-to-output path
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= START_PC;
         run     <= 1'b0;
         done    <= 1'b0;
         retired <= '0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         run     <= (state_nxt == RUN);
         done    <= (state_nxt == DONE);
         retired <= cnt_nxt;
      end
   end

endmodule
